// File: rtl/subleq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : subleq_pkg
//  Description : Shared definitions for the SUBLEQ core: state encoding,
//                address mask, instruction length and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package subleq_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH_A = 4'd1,
        S_FETCH_B = 4'd2,
        S_FETCH_C = 4'd3,
        S_READ_A  = 4'd4,
        S_READ_B  = 4'd5,
        S_WRITE_B = 4'd6,
        S_NEXT    = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    localparam logic [15:0] ADDR_MASK   = 16'h7FFF;
    localparam logic [15:0] INSTR_WORDS = 16'd3;

    // The memory space is 15 bits wide; bit 15 of any address is dropped.
    function automatic logic [15:0] word_addr(input logic [15:0] x);
        return x & ADDR_MASK;
    endfunction

    // Branch when the signed result is less than or equal to zero.
    function automatic logic branch_taken(input logic [15:0] r);
        return r[15] || (r == 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/subleq_if.sv
`default_nettype none
// ============================================================================
//  Module      : subleq_if
//  Description : Request/complete handshake between the SUBLEQ core (master)
//                and the FRAM interface (slave).
//                mem_addr/mem_wdata/mem_we/mem_start : master -> slave
//                mem_rdata/mem_done                   : slave  -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface subleq_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_start;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_start,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_start,
        output mem_rdata,
        output mem_done
    );
endinterface
`default_nettype wire

// File: rtl/subleq_core.sv
`default_nettype none
// ============================================================================
//  Module      : subleq_core
//  Description : Single-instruction (SUBLEQ) processor. Each instruction is
//                three words A, B, C at pc; mem[B] -= mem[A]; branch to C
//                when the result is <= 0, otherwise advance by three words.
//                All memory traffic goes through a start/done handshake with
//                unbounded latency.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset
//                run    - allows a new instruction to start while high
//                mem    - subleq_if.master memory handshake
//                pc     - current instruction address
//                halted - set on a halting branch, cleared only by reset
//                busy   - a memory access is outstanding
//  Revision    : 1.0 - initial release
// ============================================================================
module subleq_core
    import subleq_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter bit          HALT_ON_NEG = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        run,
    subleq_if.master         mem,
    output logic [15:0]      pc,
    output logic             halted,
    output logic             busy
);

    state_t      state_q;
    logic [15:0] pc_q;
    logic        halted_q;
    logic        busy_q;
    logic        start_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] c_q;
    logic [15:0] opa_q;
    logic [15:0] res_q;

    logic        w_done;
    logic [15:0] w_pc_p1;
    logic [15:0] w_pc_p2;
    logic [15:0] w_pc_next;
    logic [15:0] w_result;

    // A completion only counts while an access is actually outstanding.
    assign w_done    = mem.mem_done && busy_q;
    assign w_pc_p1   = word_addr(pc_q + 16'd1);
    assign w_pc_p2   = word_addr(pc_q + 16'd2);
    assign w_pc_next = word_addr(pc_q + INSTR_WORDS);
    assign w_result  = mem.mem_rdata - opa_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            c_q      <= 16'h0000;
            opa_q    <= 16'h0000;
            res_q    <= 16'h0000;
        end else begin
            // mem_start is a single-cycle pulse issued on entry to an access state.
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run && !halted_q) begin
                        state_q <= S_FETCH_A;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= word_addr(pc_q);
                    end
                end
                S_FETCH_A: begin
                    if (w_done) begin
                        a_q     <= mem.mem_rdata;
                        state_q <= S_FETCH_B;
                        start_q <= 1'b1;
                        addr_q  <= w_pc_p1;
                    end
                end
                S_FETCH_B: begin
                    if (w_done) begin
                        b_q     <= mem.mem_rdata;
                        state_q <= S_FETCH_C;
                        start_q <= 1'b1;
                        addr_q  <= w_pc_p2;
                    end
                end
                S_FETCH_C: begin
                    if (w_done) begin
                        c_q     <= mem.mem_rdata;
                        state_q <= S_READ_A;
                        start_q <= 1'b1;
                        addr_q  <= word_addr(a_q);
                    end
                end
                S_READ_A: begin
                    if (w_done) begin
                        opa_q   <= mem.mem_rdata;
                        state_q <= S_READ_B;
                        start_q <= 1'b1;
                        addr_q  <= word_addr(b_q);
                    end
                end
                S_READ_B: begin
                    if (w_done) begin
                        res_q   <= w_result;
                        state_q <= S_WRITE_B;
                        start_q <= 1'b1;
                        we_q    <= 1'b1;
                        wdata_q <= w_result;
                        addr_q  <= word_addr(b_q);
                    end
                end
                S_WRITE_B: begin
                    if (w_done) begin
                        state_q <= S_NEXT;
                        busy_q  <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                S_NEXT: begin
                    if (branch_taken(res_q) && HALT_ON_NEG && c_q[15]) begin
                        // pc stays on the halting instruction.
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        pc_q    <= branch_taken(res_q) ? word_addr(c_q) : w_pc_next;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_start = start_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_subleq_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subleq_core
//  Description : Self-checking bench for subleq_core: directed programs,
//                reset-during-access, address wrap, and randomized programs
//                compared instruction by instruction to a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subleq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic        halted;
    logic        busy;

    subleq_if mif();

    subleq_core #(
        .RESET_PC    (16'h0000),
        .HALT_ON_NEG (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .mem    (mif),
        .pc     (pc),
        .halted (halted),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] ref_pc;
    bit          ref_halt;
    logic [14:0] ref_last_b;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt   = 0;
    int wr_done_cnt = 0;
    bit rnd_lat     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // FRAM model: fixed 40-cycle latency or short random latency.
    // ------------------------------------------------------------------
    initial begin : mem_model
        bit          pending;
        int          cnt;
        logic [15:0] c_addr;
        logic [15:0] c_wd;
        logic        c_we;
        pending        = 1'b0;
        cnt            = 0;
        c_addr         = '0;
        c_wd           = '0;
        c_we           = 1'b0;
        mif.mem_done   = 1'b0;
        mif.mem_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mif.mem_done = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                chk("no_start_while_busy", {62'b0, mif.mem_start, busy}, 64'b01);
                cnt--;
                if (cnt == 0) begin
                    chk("req_held", {31'b0, mif.mem_addr, mif.mem_we, mif.mem_wdata},
                        {31'b0, c_addr, c_we, c_wd});
                    if (c_we) begin
                        mem[c_addr[14:0]] = c_wd;
                        wr_done_cnt++;
                    end else begin
                        mif.mem_rdata = mem[c_addr[14:0]];
                    end
                    mif.mem_done = 1'b1;
                    pending      = 1'b0;
                end
            end else if (mif.mem_start) begin
                chk("addr_bit15", {63'b0, mif.mem_addr[15]}, 64'b0);
                c_addr  = mif.mem_addr;
                c_we    = mif.mem_we;
                c_wd    = mif.mem_wdata;
                pending = 1'b1;
                cnt     = rnd_lat ? int'($urandom_range(1, 6)) : 40;
                start_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word-level reference: one whole instruction per call.
    // ------------------------------------------------------------------
    task automatic ref_step();
        logic [15:0] a, b, c, r;
        logic [15:0] p1, p2;
        p1 = (ref_pc + 16'd1) & 16'h7FFF;
        p2 = (ref_pc + 16'd2) & 16'h7FFF;
        a  = ref_mem[ref_pc[14:0]];
        b  = ref_mem[p1[14:0]];
        c  = ref_mem[p2[14:0]];
        r  = ref_mem[b[14:0]] - ref_mem[a[14:0]];
        ref_mem[b[14:0]] = r;
        ref_last_b = b[14:0];
        if ($signed(r) <= 0) begin
            if (c[15]) ref_halt = 1'b1;
            else       ref_pc   = {1'b0, c[14:0]};
        end else begin
            ref_pc = (ref_pc + 16'd3) & 16'h7FFF;
        end
    endtask

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state",
            {12'b0, mif.mem_start, mif.mem_we, busy, halted, mif.mem_addr, mif.mem_wdata, pc},
            {12'b0, 4'b0, 16'h0000, 16'h0000, 16'h0000});
        rst      = 1'b0;
        ref_pc   = 16'h0000;
        ref_halt = 1'b0;
        @(posedge clk);
        #2;
    endtask

    // Start one instruction, drop run once it is under way, wait for it to end.
    task automatic run_one();
        int  base_s;
        int  base_w;
        bit  seen;
        base_s = start_cnt;
        base_w = wr_done_cnt;
        seen   = 1'b0;
        run    = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (start_cnt != base_s) begin
                seen = 1'b1;
                break;
            end
        end
        run = 1'b0;
        chk("fetch_started", {63'b0, seen}, 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (wr_done_cnt != base_w) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        chk("write_done", {63'b0, seen}, 64'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
    endtask

    initial begin : main
        int  total;
        int  base;
        bit  seen;
        logic [15:0] w;

        rst = 1'b1;
        run = 1'b0;
        clear_mems();

        // Basic subtract, no branch.
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 5); poke(4, 7);
        do_reset();
        run_one();
        chk("t1_mem4", mem[4], 16'd2);
        chk("t1_pc", pc, 16'd3);
        chk("t1_halted", halted, 0);

        // Zero result branches.
        poke(0, 3); poke(1, 4); poke(2, 9); poke(3, 7); poke(4, 7);
        do_reset();
        run_one();
        chk("t2_mem4", mem[4], 16'd0);
        chk("t2_pc", pc, 16'd9);

        // Wrap-around subtraction, positive result, no branch.
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 1); poke(4, 16'h8000);
        do_reset();
        run_one();
        chk("t3_mem4", mem[4], 16'h7FFF);
        chk("t3_pc", pc, 16'd3);

        // A == B.
        poke(0, 3); poke(1, 3); poke(2, 12); poke(3, 16'h1234);
        do_reset();
        run_one();
        chk("t4_mem3", mem[3], 16'd0);
        chk("t4_pc", pc, 16'd12);

        // Branch to 7FFE, then instruction straddling the top of memory.
        poke(0, 3); poke(1, 4); poke(2, 16'h7FFE); poke(3, 0); poke(4, 0);
        poke(15'h7FFE, 10); poke(15'h7FFF, 11); poke(10, 1); poke(11, 5);
        do_reset();
        run_one();
        chk("t5_pc_top", pc, 16'h7FFE);
        run_one();
        chk("t5_mem11", mem[11], 16'd4);
        chk("t5_pc_wrap", pc, 16'h0001);

        // Halting branch.
        poke(0, 3); poke(1, 4); poke(2, 16'h8000); poke(3, 1); poke(4, 0);
        do_reset();
        run_one();
        chk("t6_mem4", mem[4], 16'hFFFF);
        chk("t6_halted", halted, 1);
        chk("t6_pc", pc, 16'd0);
        base = start_cnt;
        run  = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        run = 1'b0;
        chk("t6_no_start", start_cnt, base);
        chk("t6_still_halted", halted, 1);

        // Reset while waiting in READ_B abandons the write.
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 5); poke(4, 7);
        do_reset();
        base = start_cnt;
        seen = 1'b0;
        run  = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #2;
            if (start_cnt == base + 5) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t7_reached_read_b", {63'b0, seen}, 64'd1);
        repeat (10) @(posedge clk);
        #2;
        chk("t7_busy_before", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t7_async_reset",
            {12'b0, mif.mem_start, mif.mem_we, busy, halted, mif.mem_addr, mif.mem_wdata, pc},
            {12'b0, 4'b0, 16'h0000, 16'h0000, 16'h0000});
        @(posedge clk);
        #2;
        rst  = 1'b0;
        base = start_cnt;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (start_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t7_restart_seen", {63'b0, seen}, 64'd1);
        chk("t7_restart_req", {47'b0, mif.mem_addr, mif.mem_we}, {47'b0, 16'h0000, 1'b0});
        run = 1'b0;
        chk("t7_no_writeback", mem[4], 16'd7);

        // Randomized programs against the word-level model.
        rnd_lat = 1'b1;
        total   = 0;
        while (total < 200) begin
            for (int i = 0; i < 256; i++) begin
                w = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                poke(15'(i), w);
            end
            do_reset();
            for (int n = 0; n < 40; n++) begin
                run_one();
                ref_step();
                total++;
                chk("rnd_mem_b", mem[ref_last_b], ref_mem[ref_last_b]);
                chk("rnd_pc", pc, ref_pc);
                chk("rnd_halted", {63'b0, halted}, {63'b0, ref_halt});
                if (ref_halt) break;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
